// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART transmitter and receiver.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic {TX_IDLE, TX_TRANSFER} tx_state_e;
  typedef enum logic {RX_IDLE, RX_START} rx_state_e;

  // uclk toggles every half bit time, so a full bit is two half periods.
  function automatic int half_period(int clk_freq, int baud_rate);
    return (clk_freq / baud_rate) / 2;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver: a low level at any idle tick starts a frame; 8 data bits follow, one per tick.
module uart_rx
  import uart_pkg::*;
#(
  parameter int clk_freq  = 1000000,
  parameter int baud_rate = 9600
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] doutrx,
  output logic                 donerx
);

  localparam int half_cnt = half_period(clk_freq, baud_rate);
  localparam int cnt_w = $clog2(half_cnt + 1);
  localparam logic [cnt_w-1:0] half_m1 = cnt_w'(half_cnt - 1);

  logic [cnt_w-1:0]     count;
  logic                 uclk;
  logic                 tick;
  rx_state_e            state;
  logic [2:0]           bitcnt;
  logic [DATA_BITS-1:0] shreg;

  assign tick = (count == half_m1) && !uclk;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count  <= '0;
      uclk   <= 1'b0;
      state  <= RX_IDLE;
      bitcnt <= '0;
      shreg  <= '0;
      doutrx <= '0;
      donerx <= 1'b0;
    end else begin
      if (count == half_m1) begin
        count <= '0;
        uclk  <= ~uclk;
      end else begin
        count <= count + 1'b1;
      end
      if (tick) begin
        case (state)
          RX_IDLE: begin
            donerx <= 1'b0;
            if (rx == 1'b0) begin
              bitcnt <= '0;
              state  <= RX_START;
            end
          end
          RX_START: begin
            // First bit in ends up in bit 0 after eight right shifts.
            shreg <= {rx, shreg[DATA_BITS-1:1]};
            if (bitcnt == 3'(DATA_BITS - 1)) begin
              doutrx <= {rx, shreg[DATA_BITS-1:1]};
              donerx <= 1'b1;
              state  <= RX_IDLE;
            end else begin
              bitcnt <= bitcnt + 1'b1;
            end
          end
          default: state <= RX_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 transmitter: start bit, 8 data bits LSB first, stop bit; advances on uclk rising ticks.
module uart_tx
  import uart_pkg::*;
#(
  parameter int clk_freq  = 1000000,
  parameter int baud_rate = 9600
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 newd,
  input  logic [DATA_BITS-1:0] dintx,
  output logic                 tx,
  output logic                 donetx
);

  localparam int half_cnt = half_period(clk_freq, baud_rate);
  localparam int cnt_w = $clog2(half_cnt + 1);
  localparam logic [cnt_w-1:0] half_m1 = cnt_w'(half_cnt - 1);

  logic [cnt_w-1:0]     count;
  logic                 uclk;
  logic                 tick;
  tx_state_e            state;
  logic [3:0]           bitcnt;
  logic [DATA_BITS-1:0] data;

  // The tick is the clk cycle on which uclk goes from 0 to 1.
  assign tick = (count == half_m1) && !uclk;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count  <= '0;
      uclk   <= 1'b0;
      state  <= TX_IDLE;
      tx     <= 1'b1;
      donetx <= 1'b0;
      bitcnt <= '0;
      data   <= '0;
    end else begin
      if (count == half_m1) begin
        count <= '0;
        uclk  <= ~uclk;
      end else begin
        count <= count + 1'b1;
      end
      if (tick) begin
        case (state)
          TX_IDLE: begin
            donetx <= 1'b0;
            if (newd) begin
              data   <= dintx;
              tx     <= 1'b0;
              bitcnt <= '0;
              state  <= TX_TRANSFER;
            end else begin
              tx <= 1'b1;
            end
          end
          TX_TRANSFER: begin
            if (bitcnt == 4'(DATA_BITS)) begin
              tx     <= 1'b1;
              donetx <= 1'b1;
              state  <= TX_IDLE;
            end else begin
              tx     <= data[bitcnt[2:0]];
              bitcnt <= bitcnt + 1'b1;
            end
          end
          default: state <= TX_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/uart_top.sv
// Full-duplex UART: independent transmitter and receiver, each with its own bit clock.
module uart_top
  import uart_pkg::*;
#(
  parameter int clk_freq  = 1000000,
  parameter int baud_rate = 9600
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic [DATA_BITS-1:0] dintx,
  input  logic                 newd,
  output logic                 tx,
  output logic [DATA_BITS-1:0] doutrx,
  output logic                 donetx,
  output logic                 donerx
);

  uart_tx #(.clk_freq(clk_freq), .baud_rate(baud_rate)) utx (
    .clk    (clk),
    .rst    (rst),
    .newd   (newd),
    .dintx  (dintx),
    .tx     (tx),
    .donetx (donetx)
  );

  uart_rx #(.clk_freq(clk_freq), .baud_rate(baud_rate)) urx (
    .clk    (clk),
    .rst    (rst),
    .rx     (rx),
    .doutrx (doutrx),
    .donerx (donerx)
  );

endmodule

// File: tb/tb_uart_top.sv
// Self-checking bench for uart_top: tx frames decoded by a monitor, rx bytes checked at donerx.
module tb_uart_top;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx = 1'b1;
  logic       newd = 1'b0;
  logic [7:0] dintx = 8'h00;
  logic       tx;
  logic       donetx;
  logic       donerx;
  logic [7:0] doutrx;

  int checks = 0;
  int errors = 0;

  logic [7:0] tx_exp_q[$];
  logic [7:0] rx_exp_q[$];

  event tick_ev;
  logic prev_uclk = 1'b0;
  bit   tx_abort = 1'b0;

  localparam int FRAME_STOP_TIME = 9 * 104 * 10;

  uart_top #(.clk_freq(1000000), .baud_rate(9600)) dut (
    .clk    (clk),
    .rst    (rst),
    .rx     (rx),
    .dintx  (dintx),
    .newd   (newd),
    .tx     (tx),
    .doutrx (doutrx),
    .donetx (donetx),
    .donerx (donerx)
  );

  // clock / tick detection / watchdog
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (dut.utx.uclk === 1'b1 && prev_uclk === 1'b0) ->tick_ev;
    prev_uclk = dut.utx.uclk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation stalled, observed no completion, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic wait_ticks(int n);
    repeat (n) @(tick_ev);
  endtask

  task automatic wait_donetx();
    int n = 0;
    do begin
      @(tick_ev);
      n++;
    end while (donetx !== 1'b1 && n < 15);
    check("donetx_rise", {31'd0, donetx}, 32'd1);
  endtask

  task automatic send_tx(logic [7:0] b);
    dintx = b;
    tx_exp_q.push_back(b);
    newd = 1'b1;
    @(tick_ev);
    newd = 1'b0;
    dintx = ~b;
    wait_donetx();
    wait_ticks(1);
  endtask

  task automatic drive_rx(logic [7:0] b);
    rx_exp_q.push_back(b);
    @(tick_ev);
    rx = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(tick_ev);
      rx = b[i];
    end
    @(tick_ev);
    rx = 1'b1;
    wait_ticks(2);
  endtask

  // scoreboard: tx monitor decodes the serial line
  initial begin : tx_mon
    int         ph = 0;
    logic [7:0] bits = 8'h00;
    time        t0 = 0;
    bit         gap_chk = 1'b0;
    bit         clr_chk = 1'b0;
    logic [7:0] e;
    forever begin
      @(tick_ev);
      if (tx_abort) begin
        ph = 0;
        gap_chk = 1'b0;
        clr_chk = 1'b0;
        tx_abort = 1'b0;
      end
      if (clr_chk) begin
        check("donetx_clear", {31'd0, donetx}, 32'd0);
        clr_chk = 1'b0;
      end
      if (gap_chk) begin
        check("tx_b2b_start", {31'd0, tx}, 32'd0);
        gap_chk = 1'b0;
      end
      if (ph == 0) begin
        if (tx === 1'b0) begin
          ph = 1;
          t0 = $time;
        end
      end else if (ph <= 8) begin
        bits[ph-1] = tx;
        ph++;
      end else begin
        check("tx_stop_bit", {31'd0, tx}, 32'd1);
        check("donetx_at_stop", {31'd0, donetx}, 32'd1);
        check("tx_frame_time", 32'($time - t0), 32'(FRAME_STOP_TIME));
        if (tx_exp_q.size() == 0) begin
          check("tx_spurious_frame", {24'd0, bits}, 32'hFFFF_FFFF);
        end else begin
          e = tx_exp_q.pop_front();
          check("tx_byte", {24'd0, bits}, {24'd0, e});
        end
        gap_chk = (newd === 1'b1);
        clr_chk = 1'b1;
        ph = 0;
      end
    end
  end

  // scoreboard: rx results at each donerx tick
  initial begin : rx_mon
    bit         clr_chk = 1'b0;
    logic [7:0] last = 8'h00;
    logic [7:0] e;
    forever begin
      @(tick_ev);
      if (clr_chk) begin
        check("donerx_clear", {31'd0, donerx}, 32'd0);
        check("doutrx_hold", {24'd0, doutrx}, {24'd0, last});
        clr_chk = 1'b0;
      end
      if (donerx === 1'b1) begin
        if (rx_exp_q.size() == 0) begin
          check("rx_spurious_byte", {24'd0, doutrx}, 32'hFFFF_FFFF);
        end else begin
          e = rx_exp_q.pop_front();
          check("rx_byte", {24'd0, doutrx}, {24'd0, e});
        end
        last = doutrx;
        clr_chk = 1'b1;
      end
    end
  end

  // directed sequence
  initial begin : stim
    logic [7:0] r;

    // reset held for 5 bit times
    for (int i = 0; i < 5; i++) begin
      repeat (104) @(posedge clk);
      #1;
      check("rst_tx", {31'd0, tx}, 32'd1);
      check("rst_donetx", {31'd0, donetx}, 32'd0);
      check("rst_donerx", {31'd0, donerx}, 32'd0);
      check("rst_doutrx", {24'd0, doutrx}, 32'd0);
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(tick_ev);
      check("idle_tx", {31'd0, tx}, 32'd1);
    end

    // single transmit
    send_tx(8'hA5);

    // back-to-back transmit, newd held high
    r = 8'($urandom_range(0, 255));
    dintx = r;
    tx_exp_q.push_back(r);
    newd = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wait_donetx();
      if (i < 9) begin
        r = 8'($urandom_range(0, 255));
        dintx = r;
        tx_exp_q.push_back(r);
        if (i == 8) begin
          @(tick_ev);
          newd = 1'b0;
        end
      end
    end
    wait_ticks(2);

    // single receive, then random receives
    drive_rx(8'h3C);
    for (int i = 0; i < 10; i++) begin
      r = 8'($urandom_range(0, 255));
      drive_rx(r);
    end

    // full duplex
    fork
      send_tx(8'hFF);
      drive_rx(8'h81);
    join
    wait_ticks(1);

    // reset in the middle of a transmit frame
    dintx = 8'h00;
    newd = 1'b1;
    @(tick_ev);
    newd = 1'b0;
    wait_ticks(3);
    #300;
    check("tx_mid_frame", {31'd0, tx}, 32'd0);
    tx_abort = 1'b1;
    rst = 1'b0;
    #1;
    check("abort_tx", {31'd0, tx}, 32'd1);
    check("abort_donetx", {31'd0, donetx}, 32'd0);
    check("abort_doutrx", {24'd0, doutrx}, 32'd0);
    check("abort_uclk", {31'd0, dut.utx.uclk}, 32'd0);
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    send_tx(8'h96);

    wait_ticks(2);
    check("tx_queue_drained", 32'(tx_exp_q.size()), 32'd0);
    check("rx_queue_drained", 32'(rx_exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_top.md
Name: uart_top

Overview:
- Full-duplex 8N1 UART with one transmitter and one receiver, each running from its own bit-rate tick derived from the system clock.
- Sits between a byte-wide host interface (dintx/newd/donetx on transmit, doutrx/donerx on receive) and the serial pins tx/rx.
- No FIFO, no parity; one byte in flight per direction.

Parameters:
- clk_freq, 1000000, system clock frequency in Hz.
- baud_rate, 9600, serial bit rate in bits/s. The integer divider is clkcount = clk_freq/baud_rate (104 at the defaults).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- rx  input  1  serial receive line; idles high.
- dintx  input  8  byte to transmit; sampled when a frame starts.
- newd  input  1  transmit request; level-sensitive and checked at each bit tick while idle.
- tx  output  1  serial transmit line; idles high.
- doutrx  output  8  last received byte.
- donetx  output  1  high for one bit period at the end of each transmitted frame.
- donerx  output  1  high for one bit period after 8 data bits have been received.

Behaviour:
- Bit clock: each sub-block has a counter and a register `uclk`. uclk toggles when the counter reaches clkcount/2 (52 clocks), and the counter then restarts. One uclk period is one bit time (104 clocks).
  - A "tick" is the single clk cycle in which uclk rises.
  - Both state machines advance only on ticks.
  - The transmitter instance is named utx and exposes internal signal uclk for benches. The receiver instance is named urx.
- Reset (rst=0, async): tx=1, donetx=0, donerx=0, doutrx=0, uclk=0, all counters 0, both FSMs in IDLE.
- TX FSM, states IDLE and TRANSFER:
  - IDLE, tick with newd=1: latch dintx, drive tx=0 (start bit), clear bitcnt, donetx=0, go to TRANSFER.
  - IDLE, tick with newd=0: tx=1, donetx=0.
  - TRANSFER, ticks 1..8: tx = latched[bitcnt], LSB first, bitcnt increments.
  - TRANSFER, 9th tick: tx=1 (stop bit), donetx=1, go to IDLE.
  - donetx clears at the next tick. If newd is still 1 at that tick, a new start bit begins immediately, so back-to-back frames are exactly 10 bit times long.
  - dintx changes during a frame have no effect on the frame in progress.
- RX FSM, states IDLE and START:
  - IDLE, tick with rx=0: go to START, clear bitcnt, donerx=0. Otherwise stay in IDLE with donerx=0.
  - START, next 8 ticks: shift right with rx entering the MSB (shreg = {rx, shreg[7:1]}), so the first bit received ends up as bit 0.
  - rx is sampled with its registered value at the tick edge. A bench change made just after a tick is taken at the next tick.
  - On the 8th data sample: doutrx = shifted result, donerx=1, go to IDLE.
  - donerx clears at the next tick. doutrx holds its value until the next completed byte.
  - No stop-bit check and no mid-bit resampling. A low rx level seen in IDLE at any tick starts a frame.
- TX and RX are fully independent and may operate simultaneously.
- Reset mid-frame aborts the frame immediately and returns all outputs to their reset values.
- rx = X/Z is treated as "not 0": no start.

Decomposition:
- Package uart_pkg:
  - tx state enum {IDLE, TRANSFER}
  - rx state enum {IDLE, START}
  - localparam DATA_BITS=8
- Sub-modules uart_tx (instance utx) and uart_rx (instance urx), each carrying its own baud counter and uclk. uart_top only wires them together.

Test Plan:
- Reset: hold rst=0 for 5 bit times -> tx=1, donetx=0, donerx=0, doutrx=8'h00 throughout; release -> tx stays 1 while newd=0.
- Single TX: newd=1, dintx=8'hA5 -> after the tx falling edge, sampling tx at the next 8 uclk rises yields 1,0,1,0,0,1,0,1 (LSB first = 8'hA5). Then tx=1 with a one-bit donetx pulse; frame is 1040 clk.
- Back-to-back TX: newd held 1, 10 random dintx values loaded after each donetx rise -> each byte is reconstructed exactly from tx, with no idle gap beyond the stop bit.
- Single RX: rx=1 idle, then rx=0 for one bit time, then bits of 8'h3C LSB first, one per uclk rise -> donerx pulses one bit period and doutrx=8'h3C.
- 10 random RX bytes, each followed by 2 idle bit times with rx=1 -> doutrx matches each byte at its donerx rise.
- Full duplex plus reset abort: TX 8'hFF and RX 8'h81 overlapping -> both complete correctly. Then assert rst mid TX frame -> tx=1 and donetx=0 immediately, and the next newd starts a fresh frame.
